multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 Op  in  2  Instr[27:26] from the instruction register.
REQ-005 Funct  in  6  Instr[25:20]; Funct[5]=I bit, Funct[0]=L/S bit.
REQ-006 MemReady  in  1  memory handshake; access completes in a cycle with MemReady=1.
REQ-007 IRWrite, NextPC, RegW, MemW, Branch, ALUOp, AdrSrc  out  1 each  datapath strobes and selects.
REQ-008 ALUSrcA  out  1  0=register A, 1=PC.
REQ-009 ALUSrcB  out  2  00=register B, 01=extended immediate, 10=constant 4.
REQ-010 ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
REQ-011 Done  out  1  one-cycle pulse on instruction completion.
REQ-012 Illegal  out  1  one-cycle pulse on undefined Op.
REQ-013 State  out  4  current-state encoding, debug only.
REQ-014 Retired  out  CNT_W  count of completed instructions.

Function
REQ-015 Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9; encodings 10-15 are unreachable and SHALL recover to FETCH on the next edge.
REQ-016 Every output not listed for a state in REQ-017..REQ-026 SHALL be 0 in that state.
REQ-017 FETCH
- Outputs: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, AdrSrc=0.
- IRWrite=NextPC=MemReady (combinational gating).
- Next state: DECODE if MemReady=1, else stay in FETCH.
REQ-018 DECODE
- Outputs: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- Next state: Op=01 -> MEMADR; Op=00 with Funct[5]=0 -> EXECUTER; Op=00 with Funct[5]=1 -> EXECUTEI; Op=10 -> BRANCH; Op=11 -> FETCH with Illegal=1 in this cycle.
REQ-019 MEMADR
- Outputs: ALUSrcA=0, ALUSrcB=01.
- Next state: Funct[0]=1 -> MEMREAD, else MEMWRITE.
REQ-020 MEMREAD
- Outputs: AdrSrc=1, ResultSrc=00.
- Next state: MEMWB if MemReady=1, else stay.
REQ-021 MEMWB
- Outputs: ResultSrc=01, RegW=1, Done=1.
- Next state: FETCH.
REQ-022 MEMWRITE
- Outputs: AdrSrc=1, ResultSrc=00, MemW=1 held every cycle until MemReady=1.
- Done=MemReady.
- Next state: FETCH if MemReady=1, else stay.
REQ-023 EXECUTER
- Outputs: ALUSrcA=0, ALUSrcB=00, ALUOp=1.
- Next state: ALUWB.
REQ-024 EXECUTEI
- Outputs: ALUSrcA=0, ALUSrcB=01, ALUOp=1.
- Next state: ALUWB.
REQ-025 ALUWB
- Outputs: ResultSrc=00, RegW=1, Done=1.
- Next state: FETCH.
REQ-026 BRANCH
- Outputs: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1, Done=1.
- Next state: FETCH.
REQ-027 RegW, MemW and Branch are unconditional requests; condition gating is the downstream condition logic's job.
REQ-028 Retired increments by 1 on each edge where Done=1; Illegal does not increment it.
- Wraps from 2^CNT_W-1 to 0 with no flag.
REQ-029 Op and Funct are sampled only in DECODE and MEMADR; changes in other states have no effect.
REQ-030 MemReady is ignored outside FETCH, MEMREAD and MEMWRITE.
REQ-031 There is no wait limit: MemReady held low stalls indefinitely with outputs stable.
REQ-032 Instruction latencies in cycles, with MemReady=1 throughout:
- data-processing: 4
- branch: 3
- LDR: 5
- STR: 4
- undefined: 2

Reset
REQ-033 On a rising edge with reset=1, state SHALL become FETCH and Retired SHALL become 0, regardless of current state or MemReady.
REQ-034 Reset has priority over every transition, including a mid-stall in MEMWRITE; the MemW in progress is abandoned.
REQ-035 Outputs after reset SHALL equal the FETCH values with the current MemReady applied: all pulses 0, State=0.

Verification
REQ-036 Reset, then Op=00, Funct=000000 (register ADD), MemReady=1 -> states 0,1,6,8,0; RegW=1 only in the state-8 cycle; Retired=1.
REQ-037 Op=01, Funct[0]=1 (LDR), MemReady low for 3 cycles in MEMREAD -> state 3 held 4 cycles; ResultSrc=01 and RegW=1 in state 4; Done pulses once.
REQ-038 Op=01, Funct[0]=0 (STR), MemReady low 2 cycles -> MemW=1 for 3 consecutive cycles, then FETCH; Retired +1.
REQ-039 Op=11 -> Illegal=1 for exactly one cycle in DECODE, next state FETCH, Retired unchanged.
REQ-040 reset asserted during a MEMWRITE stall -> next cycle State=0, MemW=0, Retired=0.
REQ-041 Preload Retired to 0xFFFF by running 65535 instructions, then one branch (Op=10) -> Branch=1 in state 9 and Retired wraps to 0x0000.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle processor control unit.
// Moore FSM sequencing fetch, decode, memory access, execute and write-back
// steps, plus a retired-instruction counter. All datapath strobes are decoded
// from the registered state. The only exceptions are the MemReady-gated
// strobes in FETCH and MEMWRITE and the Illegal pulse in DECODE.
//
// Memory handshake: an access is in flight while the FSM sits in FETCH,
// MEMREAD or MEMWRITE. It completes in the cycle where MemReady=1, and the
// FSM advances on that edge. MemReady is ignored in every other state.
module multicycle_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             MemReady,
  output logic             IRWrite,
  output logic             NextPC,
  output logic             RegW,
  output logic             MemW,
  output logic             Branch,
  output logic             ALUOp,
  output logic             AdrSrc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ResultSrc,
  output logic             Done,
  output logic             Illegal,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] Retired
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] retired_q;
  logic [CNT_W-1:0] retired_d;

  // Funct[4:1] carry operation detail for the ALU decoder, not for sequencing.
  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  // Decode the datapath strobes from the current state. Anything not set is 0.
  always_comb begin
    IRWrite   = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    Done      = 1'b0;
    Illegal   = 1'b0;
    case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        NextPC    = MemReady;
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        Illegal   = (Op == 2'b11);
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        Done      = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
        Done   = MemReady;
      end
      S_EXECUTER: begin
        ALUOp = 1'b1;
      end
      S_EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      S_ALUWB: begin
        RegW = 1'b1;
        Done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
        Done      = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Count every completed instruction; wraps silently.
  assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, Done};

  // State sequencing and retired counter; reset wins over any transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
      case (state_q)
        S_FETCH:    if (MemReady) state_q <= S_DECODE;
        S_DECODE: begin
          case (Op)
            2'b00:   state_q <= Funct[5] ? S_EXECUTEI : S_EXECUTER;
            2'b01:   state_q <= S_MEMADR;
            2'b10:   state_q <= S_BRANCH;
            default: state_q <= S_FETCH;
          endcase
        end
        S_MEMADR:   state_q <= Funct[0] ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (MemReady) state_q <= S_MEMWB;
        S_MEMWB:    state_q <= S_FETCH;
        S_MEMWRITE: if (MemReady) state_q <= S_FETCH;
        S_EXECUTER: state_q <= S_ALUWB;
        S_EXECUTEI: state_q <= S_ALUWB;
        S_ALUWB:    state_q <= S_FETCH;
        S_BRANCH:   state_q <= S_FETCH;
        // Encodings 10-15 fall back to FETCH.
        default:    state_q <= S_FETCH;
      endcase
    end
  end

  assign State   = state_q;
  assign Retired = retired_q;

endmodule
